// File: rtl/adder_result_accumulator_if.sv
// Handshake bundle between an adder result producer, the accumulator and the frame consumer.
// Latency: none, wires only.
// Backpressure: in_ready/out_ready carry flow control in each direction.
interface adder_result_accumulator_if #(
    parameter int WIDTH     = 1,
    parameter int ACC_WIDTH = 16,
    parameter int CNT_W     = 8
);
    logic                 in_valid;
    logic                 in_ready;
    logic [WIDTH-1:0]     sum;
    logic                 cout;
    logic                 flush;
    logic                 out_valid;
    logic                 out_ready;
    logic [ACC_WIDTH-1:0] acc_out;
    logic [CNT_W-1:0]     out_count;
    logic                 overflow;

    // Producer/consumer side: drives results, flush and out_ready.
    modport master (
        output in_valid, sum, cout, flush, out_ready,
        input  in_ready, out_valid, acc_out, out_count, overflow
    );

    // Accumulator side.
    modport slave (
        input  in_valid, sum, cout, flush, out_ready,
        output in_ready, out_valid, acc_out, out_count, overflow
    );
endinterface

// File: rtl/adder_result_accumulator.sv
// Sums frames of {cout, sum} adder results into a saturating total with beat count and overflow flag.
// Latency: out_valid rises one cycle after the closing beat; in_ready returns one cycle after handoff.
// Backpressure: while a result is held (out_ready low) in_ready is low and inputs/flush are ignored.
module adder_result_accumulator #(
    parameter int WIDTH     = 1,
    parameter int FRAME_LEN = 4,
    parameter int ACC_WIDTH = 16,
    parameter int CNT_W     = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    adder_result_accumulator_if.slave bus
);
    localparam int EXT_W = ACC_WIDTH + 1;
    localparam logic [CNT_W-1:0] FRAME_LEN_C = CNT_W'(FRAME_LEN);

    typedef enum logic {ACCUM, HOLD} state_t;

    state_t               state_q, state_d;
    logic [ACC_WIDTH-1:0] acc_q, acc_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 ovf_q, ovf_d;

    logic                 beat;
    logic [EXT_W-1:0]     value_ext;
    logic [EXT_W-1:0]     sum_ext;
    logic [CNT_W-1:0]     cnt_inc;

    // Adder result zero-extended one bit past the accumulator so the carry out of the add is visible.
    assign value_ext = EXT_W'({bus.cout, bus.sum});
    assign sum_ext   = {1'b0, acc_q} + value_ext;
    assign cnt_inc   = cnt_q + CNT_W'(1);
    assign beat      = (state_q == ACCUM) && bus.in_valid;

    // Next-state: accumulate beats, close on full frame or non-empty flush, clear on handoff.
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        ovf_d   = ovf_q;
        case (state_q)
            ACCUM: begin
                if (beat) begin
                    cnt_d = cnt_inc;
                    if (sum_ext[ACC_WIDTH]) begin
                        acc_d = '1;
                        ovf_d = 1'b1;
                    end else begin
                        acc_d = sum_ext[ACC_WIDTH-1:0];
                    end
                end
                // A flush with nothing accumulated and no beat this cycle would make an empty frame.
                if ((beat && (cnt_inc == FRAME_LEN_C)) ||
                    (bus.flush && ((cnt_q != '0) || beat))) begin
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (bus.out_ready) begin
                    state_d = ACCUM;
                    acc_d   = '0;
                    cnt_d   = '0;
                    ovf_d   = 1'b0;
                end
            end
            default: state_d = ACCUM;
        endcase
    end

    // State and frame registers; reset drops any partial frame or held result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ACCUM;
            acc_q   <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
        end
    end

    assign bus.in_ready  = (state_q == ACCUM);
    assign bus.out_valid = (state_q == HOLD);
    assign bus.acc_out   = acc_q;
    assign bus.out_count = cnt_q;
    assign bus.overflow  = ovf_q;
endmodule
